// File: rtl/echo_pkg.sv
// Shared definitions for the echo_meter block: channel FSM encoding and the
// fixed-point constants that turn a round-trip time in ns into millimetres.
// No ports; imported by echo_channel and echo_meter.
package echo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        DONE = 2'd2,
        TMO  = 2'd3
    } echo_state_t;

    // mm = ns * 343e-6 / 2 ~= (ns * MM_MULT) >> MM_SHIFT
    localparam int unsigned MM_MULT  = 11509;
    localparam int unsigned MM_SHIFT = 26;

    // A channel reports busy while a pulse is being timed or has overrun.
    function automatic logic state_is_busy(input echo_state_t st);
        return (st == MEAS) || (st == TMO);
    endfunction

endpackage

// File: rtl/echo_channel.sv
// One echo channel: 2-FF synchroniser, edge detect, IDLE/MEAS/DONE/TMO FSM,
// cycle counter and result register (plus the mm stage with ECHO_MM_EN).
// Ports: i_clk, i_rst_n (async active-low), i_en, i_echo (raw pin);
//        o_time, o_vld (1-cycle strobe), o_tmo, o_busy, o_dist (ECHO_MM_EN only).
module echo_channel
    import echo_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int TIME_W  = 24,
    parameter int CLK_NS  = 8,
    parameter int TIMEOUT = 1000000
`ifdef ECHO_MM_EN
    ,
    parameter int DIST_W  = 12
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_echo,
    output logic [TIME_W-1:0] o_time,
    output logic              o_vld,
    output logic              o_tmo,
`ifdef ECHO_MM_EN
    output logic [DIST_W-1:0] o_dist,
`endif
    output logic              o_busy
);

    // Product width leaves ample headroom for count * CLK_NS before saturation.
    localparam int PW = CNT_W + 32;
    localparam logic [PW-1:0] TIME_MAX = PW'((64'd1 << TIME_W) - 64'd1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_dly;
    echo_state_t       r_state;
    logic [CNT_W-1:0]  r_count;
    logic [TIME_W-1:0] r_time;
    logic              r_vld;
    logic              r_tmo;

    echo_state_t       w_state_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [TIME_W-1:0] w_time_nxt;
    logic              w_vld_nxt;
    logic              w_tmo_nxt;
    logic              w_s;
    logic              w_rise;
    logic              w_fall;
    logic [PW-1:0]     w_prod;
    logic [TIME_W-1:0] w_time_sat;

    assign w_s    = r_sync2;
    assign w_rise = r_sync2 & ~r_dly;
    assign w_fall = ~r_sync2 & r_dly;

    assign w_prod     = {32'd0, r_count} * PW'(CLK_NS);
    assign w_time_sat = (w_prod > TIME_MAX) ? {TIME_W{1'b1}} : w_prod[TIME_W-1:0];

    // Synchroniser keeps running regardless of i_en so edges are never stale.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= i_echo;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_time  <= '0;
            r_vld   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_time  <= w_time_nxt;
            r_vld   <= w_vld_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_time_nxt  = r_time;
        w_vld_nxt   = 1'b0;
        w_tmo_nxt   = r_tmo;
        if (!i_en) begin
            // Abandon whatever is in flight; the held result stays as it is.
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_count_nxt = '0;
                    if (w_rise) begin
                        w_count_nxt = CNT_W'(1);
                        w_state_nxt = MEAS;
                    end
                end
                MEAS: begin
                    if (w_fall) begin
                        w_state_nxt = DONE;
                    end else if (w_s) begin
                        if (r_count == CNT_W'(TIMEOUT)) begin
                            // Overrun is reported immediately, not at the fall.
                            w_state_nxt = TMO;
                            w_time_nxt  = {TIME_W{1'b1}};
                            w_tmo_nxt   = 1'b1;
                            w_vld_nxt   = 1'b1;
                        end else begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    w_time_nxt = w_time_sat;
                    w_tmo_nxt  = 1'b0;
                    w_vld_nxt  = 1'b1;
                    if (w_rise) begin
                        w_count_nxt = CNT_W'(1);
                        w_state_nxt = MEAS;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end
                TMO: begin
                    // Wait out the overlong pulse; its fall yields no result.
                    if (!w_s) begin
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign o_tmo  = r_tmo;
    assign o_busy = state_is_busy(r_state);

`ifdef ECHO_MM_EN
    localparam int MW = TIME_W + 14;
    localparam logic [MW-1:0] DIST_MAX = MW'((64'd1 << DIST_W) - 64'd1);

    logic [TIME_W-1:0] r_time_d;
    logic              r_vld_d;
    logic [MW-1:0]     r_mm_prod;
    logic              r_mm_tmo;
    logic [MW-1:0]     w_mm_shift;

    // One pipeline stage: product of the held result, with time/strobe
    // delayed alongside so all three appear together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_time_d  <= '0;
            r_vld_d   <= 1'b0;
            r_mm_prod <= '0;
            r_mm_tmo  <= 1'b0;
        end else begin
            r_time_d  <= r_time;
            r_vld_d   <= r_vld;
            r_mm_prod <= {14'd0, r_time} * MW'(MM_MULT);
            r_mm_tmo  <= r_tmo;
        end
    end

    assign w_mm_shift = r_mm_prod >> MM_SHIFT;
    // All-ones time does not saturate the mm scale, so timeout is forced.
    assign o_dist = r_mm_tmo ? {DIST_W{1'b1}} :
                    (w_mm_shift > DIST_MAX) ? {DIST_W{1'b1}} : w_mm_shift[DIST_W-1:0];
    assign o_time = r_time_d;
    assign o_vld  = r_vld_d;
`else
    assign o_time = r_time;
    assign o_vld  = r_vld;
`endif

endmodule

// File: rtl/echo_meter.sv
// Multi-channel ultrasonic echo pulse-width meter: NCH independent channels,
// each reporting its high time in ns with a one-cycle valid strobe.
// Ports: clk, reset (async active-low), en, echo[NCH]; echo_time, echo_valid,
//        echo_timeout, busy; dist_mm only when macro ECHO_MM_EN is defined.
module echo_meter
    import echo_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int CNT_W   = 20,
    parameter int TIME_W  = 24,
    parameter int CLK_NS  = 8,
    parameter int TIMEOUT = 1000000,
    parameter int DIST_W  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NCH-1:0]        echo,
    output logic [NCH*TIME_W-1:0] echo_time,
    output logic [NCH-1:0]        echo_valid,
    output logic [NCH-1:0]        echo_timeout,
`ifdef ECHO_MM_EN
    output logic [NCH*DIST_W-1:0] dist_mm,
`endif
    output logic [NCH-1:0]        busy
);

    // Reject configurations where the counter cannot hold TIMEOUT.
    if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1 || DIST_W < 1) begin : g_bad_cfg
        $error("echo_meter: TIMEOUT must fit in CNT_W bits and DIST_W must be >= 1");
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        echo_channel #(
            .CNT_W   (CNT_W),
            .TIME_W  (TIME_W),
            .CLK_NS  (CLK_NS),
            .TIMEOUT (TIMEOUT)
`ifdef ECHO_MM_EN
            ,
            .DIST_W  (DIST_W)
`endif
        ) u_ch (
            .i_clk   (clk),
            .i_rst_n (reset),
            .i_en    (en),
            .i_echo  (echo[g]),
            .o_time  (echo_time[g*TIME_W +: TIME_W]),
            .o_vld   (echo_valid[g]),
            .o_tmo   (echo_timeout[g]),
`ifdef ECHO_MM_EN
            .o_dist  (dist_mm[g*DIST_W +: DIST_W]),
`endif
            .o_busy  (busy[g])
        );
    end

endmodule

// File: tb/tb_echo_meter.sv
module tb_echo_meter;

    localparam int NCH    = 2;
    localparam int TIME_W = 24;
    localparam int DIST_W = 12;
`ifdef ECHO_MM_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    localparam int LAT     = 4 + XL;
    localparam int TMO_LAT = 5003 + XL;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic [NCH-1:0]        echo;
    logic [NCH*TIME_W-1:0] echo_time;
    logic [NCH-1:0]        echo_valid;
    logic [NCH-1:0]        echo_timeout;
    logic [NCH-1:0]        busy;
`ifdef ECHO_MM_EN
    logic [NCH*DIST_W-1:0] dist_mm;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int vcnt [NCH];
    int vcyc [NCH];
    int dist_at [NCH];
    int t_rise;
    int t_fall;
    int base0;
    int base1;

    echo_meter #(
        .NCH(NCH), .CNT_W(20), .TIME_W(TIME_W), .CLK_NS(8),
        .TIMEOUT(5000), .DIST_W(DIST_W)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .en           (en),
        .echo         (echo),
        .echo_time    (echo_time),
        .echo_valid   (echo_valid),
        .echo_timeout (echo_timeout),
`ifdef ECHO_MM_EN
        .dist_mm      (dist_mm),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            vcnt[i] = 0;
            vcyc[i] = 0;
            dist_at[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (echo_valid[i]) begin
                vcnt[i] = vcnt[i] + 1;
                vcyc[i] = cyc;
`ifdef ECHO_MM_EN
                dist_at[i] = int'(dist_mm[i*DIST_W +: DIST_W]);
`endif
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] tm(input int ch);
        logic [31:0] v;
        v = 32'(echo_time[ch*TIME_W +: TIME_W]);
        return v;
    endfunction

    task automatic pulse(input int ch, input int n);
        @(negedge clk);
        echo[ch] = 1'b1;
        t_rise = cyc;
        repeat (n) @(negedge clk);
        echo[ch] = 1'b0;
        t_fall = cyc;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        echo  = '0;
        repeat (3) @(negedge clk);
        chk("rst_time0", tm(0), 32'd0);
        chk("rst_time1", tm(1), 32'd0);
        chk("rst_vld_tmo_busy", {26'd0, echo_valid, echo_timeout, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1000-cycle pulse on ch0
        pulse(0, 1000);
        repeat (10) @(negedge clk);
        chk("c0_strobes", vcnt[0], 1);
        chk("c0_latency", vcyc[0] - t_fall, LAT);
        chk("c0_time", tm(0), 32'd8000);
        chk("c0_tmo", echo_timeout[0], 1'b0);
        chk("c1_untouched", vcnt[1], 0);
        chk("c1_time_zero", tm(1), 32'd0);
`ifdef ECHO_MM_EN
        chk("c0_dist", dist_at[0], 1);
`endif

        // 6000-cycle pulse on ch1 overruns TIMEOUT=5000
        @(negedge clk);
        echo[1] = 1'b1;
        t_rise = cyc;
        repeat (5500) @(negedge clk);
        chk("tmo_strobe", vcnt[1], 1);
        chk("tmo_when", vcyc[1] - t_rise, TMO_LAT);
        chk("tmo_time", tm(1), 32'hFFFFFF);
        chk("tmo_flag", echo_timeout[1], 1'b1);
        chk("tmo_busy", busy[1], 1'b1);
        repeat (500) @(negedge clk);
        echo[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("tmo_no_2nd", vcnt[1], 1);
        chk("tmo_busy_off", busy[1], 1'b0);
        chk("tmo_c0_held", tm(0), 32'd8000);
`ifdef ECHO_MM_EN
        chk("tmo_dist", dist_at[1], 4095);
`endif

        // simultaneous rises, widths 300/700
        base0 = vcnt[0];
        base1 = vcnt[1];
        @(negedge clk);
        echo = 2'b11;
        repeat (300) @(negedge clk);
        echo[0] = 1'b0;
        t_fall = cyc;
        repeat (400) @(negedge clk);
        echo[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("sim_c0_strobe", vcnt[0] - base0, 1);
        chk("sim_c1_strobe", vcnt[1] - base1, 1);
        chk("sim_c0_time", tm(0), 32'd2400);
        chk("sim_c1_time", tm(1), 32'd5600);
        chk("sim_c1_tmo_clr", echo_timeout[1], 1'b0);
        chk("sim_c0_latency", vcyc[0] - t_fall, LAT);

        // equal widths: both strobes in the same cycle
        @(negedge clk);
        echo = 2'b11;
        repeat (200) @(negedge clk);
        echo = 2'b00;
        repeat (10) @(negedge clk);
        chk("eq_same_cycle", vcyc[0] - vcyc[1], 0);
        chk("eq_times", {tm(0)[15:0], tm(1)[15:0]}, {16'd1600, 16'd1600});

        // exactly TIMEOUT cycles is still a valid measurement
        pulse(1, 5000);
        repeat (10) @(negedge clk);
        chk("max_time", tm(1), 32'd40000);
        chk("max_tmo", echo_timeout[1], 1'b0);

        // reset mid-pulse
        @(negedge clk);
        echo[0] = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_time0", tm(0), 32'd0);
        chk("mrst_time1", tm(1), 32'd0);
        chk("mrst_flags", {26'd0, echo_valid, echo_timeout, busy}, 32'd0);
        echo[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        base0 = vcnt[0];
        pulse(0, 50);
        repeat (10) @(negedge clk);
        chk("post_rst_strobe", vcnt[0] - base0, 1);
        chk("post_rst_time", tm(0), 32'd400);

        // drop en mid-pulse
        base0 = vcnt[0];
        @(negedge clk);
        echo[0] = 1'b1;
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("en_busy_off", busy[0], 1'b0);
        repeat (148) @(negedge clk);
        echo[0] = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        chk("en_no_strobe", vcnt[0] - base0, 0);
        chk("en_held", tm(0), 32'd400);

        // single-cycle glitch
        pulse(0, 1);
        repeat (10) @(negedge clk);
        chk("glitch_strobe", vcnt[0] - base0, 1);
        chk("glitch_time", tm(0), 32'd8);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/echo_meter.md
Name: echo_meter

Overview:
- Multi-channel successor to the single-channel echo pulse-width counter.
- Measures the high time of NCH asynchronous ultrasonic echo inputs in parallel and reports each width in nanoseconds with a one-cycle valid strobe.
- Adds input synchronisation, timeout detection, a global enable, a busy status and an optional millimetre distance output.
- Sits between the ultrasonic sensor pins and the car's obstacle-avoidance logic.

Parameters:
- NCH, 2: number of independent echo channels.
- CNT_W, 20: per-channel cycle counter width.
- TIME_W, 24: width of each echo_time result.
- CLK_NS, 8: clock period in ns, used as the cycle-to-ns multiplier.
- TIMEOUT, 1000000: maximum measured cycles; must be ≤ 2^CNT_W-1.
- DIST_W, 12: width of each dist_mm result; used only with ECHO_MM_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low forces every channel to IDLE.
- echo  in  NCH  raw asynchronous echo inputs, one bit per channel.
- echo_time  out  NCH*TIME_W  per-channel pulse width in ns; channel i occupies bits [i*TIME_W +: TIME_W].
- echo_valid  out  NCH  one-cycle strobe per channel on a result update.
- echo_timeout  out  NCH  per-channel flag; set when that channel's latest result was a timeout.
- busy  out  NCH  high while the channel is in MEAS or TMO.

Behaviour:
- Reset (reset=0, asynchronous): all sync flops, counters, echo_time, echo_valid, echo_timeout, busy and dist_mm go to 0; FSMs go to IDLE.
- Synchronisation: each echo bit passes through a 2-FF synchroniser (s), then one delay register (d).
  - rise = s & ~d; fall = ~s & d.
- Per-channel FSM, states IDLE, MEAS, DONE, TMO:
  - IDLE: count=0. On rise, load count=1 and go to MEAS.
  - MEAS: while s=1, count+1.
    - On fall, go to DONE.
    - If count reaches TIMEOUT while s is still 1, go to TMO.
  - DONE (one cycle): latch echo_time = count*CLK_NS.
    - If the product exceeds 2^TIME_W-1, saturate to all ones.
    - Clear echo_timeout.
    - Next state is MEAS (count=1) if rise, else IDLE.
  - TMO: on entry, latch echo_time = all ones, set echo_timeout, pulse echo_valid.
    - Stay in TMO until s=0, then go to IDLE.
    - The trailing fall generates no second result.
- Count semantics: a clean N-cycle high pulse on echo yields count=N; the synchroniser latency cancels.
- echo_valid: high for exactly the cycle after echo_time updates. echo_time holds until the next update.
- Latency: echo_valid rises 4 cycles after the falling edge of echo at the pin (2 sync + 1 edge + DONE).
- en=0: all channels go to IDLE on the next clock. An in-progress measurement is discarded with no valid strobe; held results are unchanged.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- 1-cycle glitch: it is a valid measurement (count=1).

Optional Feature:
- Macro: ECHO_MM_EN.
- Defined:
  - Adds output dist_mm, NCH*DIST_W bits.
  - dist_mm = (echo_time * 11509) >> 26, i.e. ns × 0.0001715 = mm at 343 m/s round trip.
  - The product is TIME_W+14 bits and is registered one stage after echo_time; the result saturates at 2^DIST_W-1.
  - On timeout, dist_mm = all ones.
  - echo_valid is delayed one cycle so it aligns with dist_mm; echo_time is delayed one cycle alongside it.
- Undefined: port absent, no multiplier, latency as above.

Decomposition:
- Package echo_pkg holds:
  - the FSM state encoding (IDLE=2'd0, MEAS=2'd1, DONE=2'd2, TMO=2'd3);
  - constant MM_MULT=11509;
  - constant MM_SHIFT=26.
- Sub-module echo_channel:
  - contains one channel's synchroniser, edge detect, FSM, counter and result register;
  - is instantiated NCH times by a generate loop in echo_meter;
  - the mm stage sits in echo_channel under the macro.

Test Plan:
- Reset then a 1000-cycle pulse on ch0 → one echo_valid[0] 4 cycles after the fall; echo_time[0]=8000, echo_timeout[0]=0, ch1 untouched.
- TIMEOUT=5000, 6000-cycle pulse on ch1 → echo_valid[1] once around cycle 5000, echo_time[1]=24'hFFFFFF, echo_timeout[1]=1, busy[1] high until the fall, no strobe at the fall.
- Simultaneous rises on ch0/ch1 of widths 300/700 → independent strobes; echo_time 2400 and 5600.
- Assert reset mid-pulse, release, then a 50-cycle pulse → all outputs 0 during reset; next result 400.
- Drop en mid-pulse → no strobe, previous result retained. 1-cycle glitch with en=1 → echo_time=8.
- ECHO_MM_EN, 100000-cycle pulse → echo_time=800000, dist_mm=137, echo_valid aligned with dist_mm.
